// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares one FIFO write port among N_REQ requesters.
// Each requester uses a valid/ready handshake. A granted requester keeps the
// port for up to MAX_BURST accepted beats. The grant is released early if the
// granted requester drops valid. Every release costs one IDLE cycle before the
// next grant is issued. The accepted beat reaches the FIFO in the same cycle.
//
// Ports
//   i_clk          FIFO write-side clock; all logic on posedge
//   i_reset        synchronous, active-high reset
//   i_req_valid    per-requester valid, held until accepted
//   i_req_data     packed data; requester k at [k*NB_DATA +: NB_DATA]
//   o_req_ready    per-requester ready, one-hot or zero
//   i_fifo_full    FIFO full flag (i_clk domain)
//   o_fifo_wr_en   FIFO write enable (high on an accepted beat)
//   o_fifo_data    FIFO write data (zero when not writing)
//   o_grant_id     index of the current or most recent grant (registered)
//   o_busy         high while a grant is active
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NB_DATA   = 4,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0]   i_req_data,
    output logic [N_REQ-1:0]           o_req_ready,
    input  logic                       i_fifo_full,
    output logic                       o_fifo_wr_en,
    output logic [NB_DATA-1:0]         o_fifo_data,
    output logic [$clog2(N_REQ)-1:0]   o_grant_id,
    output logic                       o_busy
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [GW-1:0]   rr_ptr;
    logic [CW-1:0]   beat_cnt;

    logic [NB_DATA-1:0] req_data [N_REQ];
    logic [GW-1:0]      next_grant;
    logic               any_valid;
    logic [GW-1:0]      grant_inc;
    logic               transfer;
    logic               last_beat;

    // Unpack the flat data bus so the granted slice is a plain array select.
    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign req_data[k] = i_req_data[k*NB_DATA +: NB_DATA];
    end

    // Round-robin pick: scan rr_ptr, rr_ptr+1, ... modulo N_REQ and take the
    // first requester with valid set.
    always_comb begin
        int            idx;
        logic [GW-1:0] idx_g;
        // NOTE: every variable assigned here gets a default first, otherwise
        // paths that skip an assignment would infer a latch.
        next_grant = rr_ptr;
        any_valid  = 1'b0;
        idx        = 0;
        idx_g      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_g = idx[GW-1:0];
            if (!any_valid && i_req_valid[idx_g]) begin
                any_valid  = 1'b1;
                next_grant = idx_g;
            end
        end
    end

    assign grant_inc = (o_grant_id == GW'(N_REQ - 1)) ? '0 : o_grant_id + 1'b1;
    assign transfer  = (state == GRANT) && i_req_valid[o_grant_id] && !i_fifo_full;
    assign last_beat = (beat_cnt == CW'(MAX_BURST - 1));

    // Handshake outputs are combinational so an accepted beat is written to
    // the FIFO in the same cycle; FIFO full removes ready immediately.
    always_comb begin
        o_req_ready = '0;
        if (state == GRANT && !i_fifo_full) begin
            o_req_ready[o_grant_id] = 1'b1;
        end
    end

    assign o_fifo_wr_en = transfer;
    assign o_fifo_data  = transfer ? req_data[o_grant_id] : '0;
    assign o_busy       = (state == GRANT);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            o_grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        o_grant_id <= next_grant;
                        beat_cnt   <= '0;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (transfer) begin
                        // Counter tops out at MAX_BURST on the releasing beat.
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= grant_inc;
                        end
                    end else if (!i_req_valid[o_grant_id]) begin
                        // Granted requester went away; full alone never releases.
                        state  <= IDLE;
                        rr_ptr <= grant_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Drives two arbiters (MAX_BURST=4 and MAX_BURST=1) from the same stimulus and
// compares every output, every cycle, with a behavioural reference model. The
// model tracks only "who owns the port, how many beats so far, where the
// round-robin search starts". Directed scenarios add explicit expectations.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NB = 4;
    localparam int NR = 4;
    localparam int GW = 2;
    localparam int MB [2] = '{4, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NR-1:0]        valid;
    logic [NR*NB-1:0]     data;
    logic                 full;

    logic [NR-1:0]        ready [2];
    logic                 wr_en [2];
    logic [NB-1:0]        fdata [2];
    logic [GW-1:0]        gid   [2];
    logic                 busy  [2];

    fifo_wr_arbiter #(.NB_DATA(NB), .N_REQ(NR), .MAX_BURST(4)) u_dut_b4 (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (valid),
        .i_req_data   (data),
        .o_req_ready  (ready[0]),
        .i_fifo_full  (full),
        .o_fifo_wr_en (wr_en[0]),
        .o_fifo_data  (fdata[0]),
        .o_grant_id   (gid[0]),
        .o_busy       (busy[0])
    );

    fifo_wr_arbiter #(.NB_DATA(NB), .N_REQ(NR), .MAX_BURST(1)) u_dut_b1 (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (valid),
        .i_req_data   (data),
        .o_req_ready  (ready[1]),
        .i_fifo_full  (full),
        .o_fifo_wr_en (wr_en[1]),
        .o_fifo_data  (fdata[1]),
        .o_grant_id   (gid[1]),
        .o_busy       (busy[1])
    );

    int errors = 0;
    int checks = 0;

    // Reference model state, one set per DUT.
    bit m_busy  [2];
    int m_grant [2];
    int m_rr    [2];
    int m_beats [2];

    // Last sampled DUT outputs, for scenario-level expectations.
    logic          last_wr    [2];
    logic [NB-1:0] last_data  [2];
    logic [GW-1:0] last_gid   [2];
    logic          last_busy  [2];
    logic [NR-1:0] last_ready [2];

    // Requesters whose beat the MAX_BURST=4 model accepted in the last cycle.
    logic [NR-1:0] acc;

    // One clock cycle: compare both DUTs with the model at negedge, advance
    // the model to the next edge, return 1 time unit after posedge.
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            logic [NR-1:0] er;
            logic          ex;
            logic [NB-1:0] ed;
            er = '0;
            if (m_busy[d] && !full) er[m_grant[d]] = 1'b1;
            ex = m_busy[d] && !full && valid[m_grant[d]];
            ed = ex ? data[m_grant[d]*NB +: NB] : '0;

            checks++;
            if (ready[d] !== er) begin
                errors++;
                $display("FAIL ready dut%0d t=%0t: got %b expected %b", d, $time, ready[d], er);
            end
            checks++;
            if (wr_en[d] !== ex) begin
                errors++;
                $display("FAIL wr_en dut%0d t=%0t: got %b expected %b", d, $time, wr_en[d], ex);
            end
            checks++;
            if (fdata[d] !== ed) begin
                errors++;
                $display("FAIL fifo_data dut%0d t=%0t: got %h expected %h", d, $time, fdata[d], ed);
            end
            checks++;
            if (busy[d] !== m_busy[d]) begin
                errors++;
                $display("FAIL busy dut%0d t=%0t: got %b expected %b", d, $time, busy[d], m_busy[d]);
            end
            checks++;
            if (gid[d] !== GW'(m_grant[d])) begin
                errors++;
                $display("FAIL grant_id dut%0d t=%0t: got %0d expected %0d", d, $time, gid[d], m_grant[d]);
            end

            last_wr[d]    = wr_en[d];
            last_data[d]  = fdata[d];
            last_gid[d]   = gid[d];
            last_busy[d]  = busy[d];
            last_ready[d] = ready[d];
            if (d == 0) acc = ex ? er : '0;

            // Advance the model by one edge.
            if (rst) begin
                m_busy[d]  = 1'b0;
                m_grant[d] = 0;
                m_rr[d]    = 0;
                m_beats[d] = 0;
            end else if (!m_busy[d]) begin
                for (int i = 0; i < NR; i++) begin
                    int k;
                    k = (m_rr[d] + i) % NR;
                    if (!m_busy[d] && valid[k]) begin
                        m_busy[d]  = 1'b1;
                        m_grant[d] = k;
                        m_beats[d] = 0;
                    end
                end
            end else if (ex) begin
                m_beats[d]++;
                if (m_beats[d] == MB[d]) begin
                    m_busy[d] = 1'b0;
                    m_rr[d]   = (m_grant[d] + 1) % NR;
                end
            end else if (!valid[m_grant[d]]) begin
                m_busy[d] = 1'b0;
                m_rr[d]   = (m_grant[d] + 1) % NR;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        valid = '0;
        full  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = 4'b1111;
        full  = 1'b0;
        data  = 16'h4321;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (last_ready[0] !== 4'b0000 || last_wr[0] !== 1'b0 || last_busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got ready=%b wr=%b busy=%b expected 0000/0/0",
                         last_ready[0], last_wr[0], last_busy[0]);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (last_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_cycle: got busy=%b expected 0", last_busy[0]);
        end
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (last_busy[d] !== 1'b1 || last_gid[d] !== 2'd0) begin
                errors++;
                $display("FAIL reset_first_grant dut%0d: got busy=%b gid=%0d expected 1/0",
                         d, last_busy[d], last_gid[d]);
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        valid = 4'b1111;
        for (int k = 0; k < NR; k++) data[k*NB +: NB] = NB'(k * 4);
        for (int i = 0; i < 22; i++) begin
            logic          exp_wr;
            logic [GW-1:0] exp_g;
            logic [NB-1:0] exp_d;
            step();
            exp_wr = (i % 5) != 0;
            checks++;
            if (last_wr[0] !== exp_wr) begin
                errors++;
                $display("FAIL rr_wr_pattern cycle %0d: got %b expected %b", i, last_wr[0], exp_wr);
            end
            if (exp_wr) begin
                exp_g = GW'(((i - 1) / 5) % 4);
                exp_d = NB'(int'(exp_g) * 4 + (i - 1) % 5);
                checks++;
                if (last_gid[0] !== exp_g || last_data[0] !== exp_d) begin
                    errors++;
                    $display("FAIL rr_beat cycle %0d: got gid=%0d data=%h expected gid=%0d data=%h",
                             i, last_gid[0], last_data[0], exp_g, exp_d);
                end
            end
            // Next beat of an accepted requester carries the next sequence number.
            for (int k = 0; k < NR; k++)
                if (acc[k]) data[k*NB +: 2] = data[k*NB +: 2] + 2'd1;
        end
    endtask

    task automatic test_short_burst();
        apply_reset();
        valid = 4'b0100;
        data  = 16'h0A00;
        step();
        step();
        checks++;
        if (last_wr[0] !== 1'b1 || last_data[0] !== 4'hA) begin
            errors++;
            $display("FAIL short_beat_a: got wr=%b data=%h expected 1/a", last_wr[0], last_data[0]);
        end
        data = 16'h0B00;
        step();
        checks++;
        if (last_wr[0] !== 1'b1 || last_data[0] !== 4'hB) begin
            errors++;
            $display("FAIL short_beat_b: got wr=%b data=%h expected 1/b", last_wr[0], last_data[0]);
        end
        valid = 4'b0000;
        step();
        checks++;
        if (last_wr[0] !== 1'b0) begin
            errors++;
            $display("FAIL short_release: got wr=%b expected 0", last_wr[0]);
        end
        valid = 4'b1001;
        data  = 16'h3001;
        step();
        step();
        checks++;
        if (last_busy[0] !== 1'b1 || last_gid[0] !== 2'd3) begin
            errors++;
            $display("FAIL short_next_grant: got busy=%b gid=%0d expected 1/3", last_busy[0], last_gid[0]);
        end
    endtask

    task automatic test_backpressure();
        int n;
        apply_reset();
        valid = 4'b0010;
        data  = 16'h0050;
        n     = 0;
        step();
        step();
        n += int'(last_wr[0]);
        step();
        n += int'(last_wr[0]);
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (last_ready[0] !== 4'b0000 || last_wr[0] !== 1'b0 ||
                last_gid[0] !== 2'd1 || last_busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_frozen cycle %0d: got ready=%b wr=%b gid=%0d busy=%b expected 0000/0/1/1",
                         i, last_ready[0], last_wr[0], last_gid[0], last_busy[0]);
            end
        end
        full = 1'b0;
        step();
        n += int'(last_wr[0]);
        step();
        n += int'(last_wr[0]);
        step();
        checks++;
        if (n != 4 || last_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_burst_total: got beats=%0d busy=%b expected 4/0", n, last_busy[0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        valid = 4'b0010;
        data  = 16'h0070;
        step();
        step();
        rst = 1'b1;
        step();
        rst   = 1'b0;
        valid = 4'b0110;
        step();
        checks++;
        if (last_ready[0] !== 4'b0000 || last_wr[0] !== 1'b0 || last_data[0] !== 4'h0 ||
            last_busy[0] !== 1'b0 || last_gid[0] !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ready=%b wr=%b data=%h busy=%b gid=%0d expected all zero",
                     last_ready[0], last_wr[0], last_data[0], last_busy[0], last_gid[0]);
        end
        step();
        checks++;
        if (last_busy[0] !== 1'b1 || last_gid[0] !== 2'd1) begin
            errors++;
            $display("FAIL mid_reset_regrant: got busy=%b gid=%0d expected 1/1", last_busy[0], last_gid[0]);
        end
    endtask

    task automatic test_sparse_burst1();
        apply_reset();
        valid = 4'b1010;
        data  = 16'h9030;
        for (int i = 0; i < 8; i++) begin
            logic exp_wr;
            step();
            exp_wr = (i % 2) == 1;
            checks++;
            if (last_wr[1] !== exp_wr) begin
                errors++;
                $display("FAIL sparse_wr cycle %0d: got %b expected %b", i, last_wr[1], exp_wr);
            end
            if (exp_wr) begin
                checks++;
                if (last_gid[1] !== ((i % 4 == 1) ? 2'd1 : 2'd3)) begin
                    errors++;
                    $display("FAIL sparse_grant cycle %0d: got %0d expected %0d",
                             i, last_gid[1], (i % 4 == 1) ? 1 : 3);
                end
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        acc = '0;
        for (int c = 0; c < 1500; c++) begin
            rst  = ($urandom_range(99) == 0);
            full = ($urandom_range(3) == 0);
            for (int k = 0; k < NR; k++) begin
                if (!valid[k] || acc[k]) begin
                    valid[k]         = ($urandom_range(1) == 1);
                    data[k*NB +: NB] = NB'($urandom);
                end
            end
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        valid = '0;
        data  = '0;
        full  = 1'b0;
        acc   = '0;
        for (int d = 0; d < 2; d++) begin
            m_busy[d]  = 1'b0;
            m_grant[d] = 0;
            m_rr[d]    = 0;
            m_beats[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_short_burst();
        test_backpressure();
        test_reset_mid_burst();
        test_sparse_burst1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
